// File: rtl/mem_wb_regfile.sv
// MEM/WB pipeline register plus the architectural integer register file.
// Captures the memory stage's write-back triple every unstalled cycle and
// retires it into the register file on the following edge. Decode reads two
// ports with write-through bypass; execute sees a forwarding tap of the WB
// stage. A free-running counter tracks retired instructions.
module mem_wb_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int CNT_W = 64,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mem_valid,
  input  logic [IDX_W-1:0] mem_rd_idx,
  input  logic             mem_rd_en,
  input  logic [XLEN-1:0]  mem_rd_data,
  input  logic             wb_stall,
  input  logic             wb_flush,
  input  logic [IDX_W-1:0] rs1_idx,
  input  logic [IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             wb_fwd_en,
  output logic [IDX_W-1:0] wb_fwd_idx,
  output logic [XLEN-1:0]  wb_fwd_data,
  output logic [CNT_W-1:0] instret
);

  logic             wb_valid_q,   wb_valid_d;
  logic             wb_rd_en_q,   wb_rd_en_d;
  logic [IDX_W-1:0] wb_rd_idx_q,  wb_rd_idx_d;
  logic [XLEN-1:0]  wb_rd_data_q, wb_rd_data_d;
  logic [CNT_W-1:0] instret_q,    instret_d;
  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];

  logic retire;
  logic rf_write;

  // The WB instruction leaves the stage only when it is live and not frozen.
  assign retire   = wb_valid_q & ~wb_stall;
  assign rf_write = retire & wb_rd_en_q & (wb_rd_idx_q != '0);

  // WB register next state: stall holds everything and outranks flush.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wb_valid_d   = wb_valid_q;
    wb_rd_en_d   = wb_rd_en_q;
    wb_rd_idx_d  = wb_rd_idx_q;
    wb_rd_data_d = wb_rd_data_q;
    if (!wb_stall) begin
      wb_rd_idx_d  = mem_rd_idx;
      wb_rd_data_d = mem_rd_data;
      if (wb_flush) begin
        wb_valid_d = 1'b0;
        wb_rd_en_d = 1'b0;
      end else begin
        wb_valid_d = mem_valid;
        wb_rd_en_d = mem_valid & mem_rd_en;
      end
    end
  end

  // Register file next state: a single write port driven by the retiring WB entry.
  always_comb begin
    regs_d = regs_q;
    if (rf_write) regs_d[wb_rd_idx_q] = wb_rd_data_q;
  end

  // Retired-instruction counter; wraps silently at full width.
  always_comb begin
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // WB pipeline register and instret state.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rstn) begin
      wb_valid_q   <= 1'b0;
      wb_rd_en_q   <= 1'b0;
      wb_rd_idx_q  <= '0;
      wb_rd_data_q <= '0;
      instret_q    <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_rd_en_q   <= wb_rd_en_d;
      wb_rd_idx_q  <= wb_rd_idx_d;
      wb_rd_data_q <= wb_rd_data_d;
      instret_q    <= instret_d;
    end
  end

  // Architectural register storage.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the register file is reset to zero because architectural state must be defined after reset; this forces flops rather than a RAM macro.
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Read port 1: x0 reads zero, then same-cycle write bypass, then storage.
  always_comb begin
    rs1_data = regs_q[rs1_idx];
    if (rs1_idx == '0)
      rs1_data = '0;
    else if (retire && wb_rd_en_q && (wb_rd_idx_q == rs1_idx))
      rs1_data = wb_rd_data_q;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data = regs_q[rs2_idx];
    if (rs2_idx == '0)
      rs2_data = '0;
    else if (retire && wb_rd_en_q && (wb_rd_idx_q == rs2_idx))
      rs2_data = wb_rd_data_q;
  end

  // Forwarding tap is visible even while WB is stalled.
  assign wb_fwd_en   = wb_valid_q & wb_rd_en_q & (wb_rd_idx_q != '0);
  assign wb_fwd_idx  = wb_rd_idx_q;
  assign wb_fwd_data = wb_rd_data_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Directed bench for mem_wb_regfile. A second instance with a 3-bit counter
// shares all inputs so counter wrap can be exercised in a few cycles.
module tb_mem_wb_regfile;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_rd_en, wb_stall, wb_flush;
  logic [4:0]  mem_rd_idx, rs1_idx, rs2_idx;
  logic [31:0] mem_rd_data;
  logic [31:0] rs1_data, rs2_data, wb_fwd_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_idx;
  logic [63:0] instret;

  logic [31:0] s_rs1_data, s_rs2_data, s_wb_fwd_data;
  logic        s_wb_fwd_en;
  logic [4:0]  s_wb_fwd_idx;
  logic [2:0]  s_instret;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_regfile dut (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .mem_rd_idx(mem_rd_idx),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .wb_stall(wb_stall),
    .wb_flush(wb_flush), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_fwd_en(wb_fwd_en),
    .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data), .instret(instret)
  );

  mem_wb_regfile #(.CNT_W(3)) dut_small (
    .clk(clk), .rstn(rstn), .mem_valid(mem_valid), .mem_rd_idx(mem_rd_idx),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .wb_stall(wb_stall),
    .wb_flush(wb_flush), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .wb_fwd_en(s_wb_fwd_en),
    .wb_fwd_idx(s_wb_fwd_idx), .wb_fwd_data(s_wb_fwd_data), .instret(s_instret)
  );

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(input logic v, input logic en, input logic [4:0] idx,
                           input logic [31:0] data);
    mem_valid   = v;
    mem_rd_en   = en;
    mem_rd_idx  = idx;
    mem_rd_data = data;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    rs1_idx  = 5'd0;
    rs2_idx  = 5'd0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    rs1_idx = 5'd5;
    rs2_idx = 5'd0;
    #1;
    n_cmp++; if (rs1_data !== 32'd0) begin n_err++; $display("FAIL reset_rs1 got %h want 0", rs1_data); end
    n_cmp++; if (rs2_data !== 32'd0) begin n_err++; $display("FAIL reset_rs2 got %h want 0", rs2_data); end
    n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL reset_instret got %0d want 0", instret); end
    n_cmp++; if (wb_fwd_en !== 1'b0) begin n_err++; $display("FAIL reset_fwd_en got %b want 0", wb_fwd_en); end
    n_cmp++; if (wb_fwd_idx !== 5'd0 || wb_fwd_data !== 32'd0) begin
      n_err++; $display("FAIL reset_fwd got idx %0d data %h want 0/0", wb_fwd_idx, wb_fwd_data); end
  endtask

  task automatic test_write_bypass();
    do_reset();
    drive_mem(1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
    tick();
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    rs1_idx = 5'd3;
    rs2_idx = 5'd3;
    #1;
    n_cmp++; if (wb_fwd_en !== 1'b1 || wb_fwd_idx !== 5'd3 || wb_fwd_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_fwd got en %b idx %0d data %h want 1/3/deadbeef", wb_fwd_en, wb_fwd_idx, wb_fwd_data); end
    n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_bypass_rs1 got %h want deadbeef", rs1_data); end
    n_cmp++; if (rs2_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_bypass_rs2 got %h want deadbeef", rs2_data); end
    n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL wr_instret_pre got %0d want 0", instret); end
    tick();
    n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_reg3 got %h want deadbeef", rs1_data); end
    n_cmp++; if (instret !== 64'd1) begin n_err++; $display("FAIL wr_instret got %0d want 1", instret); end
    n_cmp++; if (wb_fwd_en !== 1'b0) begin n_err++; $display("FAIL wr_fwd_clear got %b want 0", wb_fwd_en); end
  endtask

  task automatic test_x0();
    do_reset();
    drive_mem(1'b1, 1'b1, 5'd0, 32'h12345678);
    tick();
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    rs1_idx = 5'd0;
    #1;
    n_cmp++; if (wb_fwd_en !== 1'b0) begin n_err++; $display("FAIL x0_fwd_en got %b want 0", wb_fwd_en); end
    n_cmp++; if (rs1_data !== 32'd0) begin n_err++; $display("FAIL x0_bypass got %h want 0", rs1_data); end
    tick();
    n_cmp++; if (rs1_data !== 32'd0) begin n_err++; $display("FAIL x0_read got %h want 0", rs1_data); end
    n_cmp++; if (instret !== 64'd1) begin n_err++; $display("FAIL x0_instret got %0d want 1", instret); end
  endtask

  task automatic test_stall();
    do_reset();
    drive_mem(1'b1, 1'b1, 5'd7, 32'h11);
    tick();
    drive_mem(1'b1, 1'b1, 5'd8, 32'h88);
    wb_stall = 1'b1;
    rs1_idx  = 5'd7;
    rs2_idx  = 5'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (wb_fwd_en !== 1'b1 || wb_fwd_idx !== 5'd7 || wb_fwd_data !== 32'h11) begin
        n_err++; $display("FAIL stall_hold[%0d] got en %b idx %0d data %h want 1/7/11", i, wb_fwd_en, wb_fwd_idx, wb_fwd_data); end
      n_cmp++; if (rs1_data !== 32'd0) begin n_err++; $display("FAIL stall_no_bypass[%0d] got %h want 0", i, rs1_data); end
      tick();
    end
    n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL stall_instret got %0d want 0", instret); end
    n_cmp++; if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      n_err++; $display("FAIL stall_unwritten got %h/%h want 0/0", rs1_data, rs2_data); end
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    wb_stall = 1'b0;
    #1;
    n_cmp++; if (rs1_data !== 32'h11) begin n_err++; $display("FAIL stall_release_bypass got %h want 11", rs1_data); end
    tick();
    n_cmp++; if (rs1_data !== 32'h11) begin n_err++; $display("FAIL stall_reg7 got %h want 11", rs1_data); end
    n_cmp++; if (instret !== 64'd1) begin n_err++; $display("FAIL stall_release_instret got %0d want 1", instret); end
    tick();
    n_cmp++; if (instret !== 64'd1 || rs2_data !== 32'd0) begin
      n_err++; $display("FAIL stall_once got instret %0d reg8 %h want 1/0", instret, rs2_data); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_mem(1'b1, 1'b1, 5'd9, 32'hAA);
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    rs1_idx = 5'd9;
    #1;
    n_cmp++; if (wb_fwd_en !== 1'b0) begin n_err++; $display("FAIL flush_bubble got %b want 0", wb_fwd_en); end
    tick();
    n_cmp++; if (rs1_data !== 32'd0 || instret !== 64'd0) begin
      n_err++; $display("FAIL flush_no_retire got reg9 %h instret %0d want 0/0", rs1_data, instret); end
    drive_mem(1'b1, 1'b1, 5'd10, 32'h55);
    tick();
    drive_mem(1'b1, 1'b1, 5'd9, 32'hAA);
    wb_stall = 1'b1;
    wb_flush = 1'b1;
    tick();
    n_cmp++; if (wb_fwd_en !== 1'b1 || wb_fwd_idx !== 5'd10 || wb_fwd_data !== 32'h55) begin
      n_err++; $display("FAIL flush_stall_hold got en %b idx %0d data %h want 1/10/55", wb_fwd_en, wb_fwd_idx, wb_fwd_data); end
    n_cmp++; if (instret !== 64'd0) begin n_err++; $display("FAIL flush_stall_instret got %0d want 0", instret); end
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    rs2_idx = 5'd10;
    tick();
    n_cmp++; if (rs2_data !== 32'h55 || instret !== 64'd1) begin
      n_err++; $display("FAIL flush_stall_retire got reg10 %h instret %0d want 55/1", rs2_data, instret); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rs1_idx = 5'd5;
    rs2_idx = 5'd6;
    drive_mem(1'b1, 1'b1, 5'd5, 32'h1);
    tick();
    drive_mem(1'b1, 1'b1, 5'd5, 32'h2);
    #1;
    n_cmp++; if (rs1_data !== 32'h1) begin n_err++; $display("FAIL b2b_first got %h want 1", rs1_data); end
    tick();
    drive_mem(1'b1, 1'b1, 5'd6, 32'h3);
    #1;
    n_cmp++; if (rs1_data !== 32'h2) begin n_err++; $display("FAIL b2b_second got %h want 2", rs1_data); end
    tick();
    drive_mem(1'b1, 1'b0, 5'd5, 32'hFF);
    #1;
    n_cmp++; if (rs1_data !== 32'h2 || rs2_data !== 32'h3) begin
      n_err++; $display("FAIL b2b_order got %h/%h want 2/3", rs1_data, rs2_data); end
    tick();
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (wb_fwd_en !== 1'b0 || rs1_data !== 32'h2) begin
      n_err++; $display("FAIL b2b_store got en %b reg5 %h want 0/2", wb_fwd_en, rs1_data); end
    tick();
    n_cmp++; if (instret !== 64'd4 || rs1_data !== 32'h2) begin
      n_err++; $display("FAIL b2b_final got instret %0d reg5 %h want 4/2", instret, rs1_data); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_mem(1'b1, 1'b0, 5'd1, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    n_cmp++; if (s_instret !== 3'd7) begin n_err++; $display("FAIL wrap_pre got %0d want 7", s_instret); end
    tick();
    n_cmp++; if (s_instret !== 3'd0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", s_instret); end
    n_cmp++; if (instret !== 64'd8) begin n_err++; $display("FAIL wrap_wide got %0d want 8", instret); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_mem(1'b1, 1'b1, 5'd2, 32'h22);
    tick();
    drive_mem(1'b1, 1'b1, 5'd4, 32'h44);
    tick();
    drive_mem(1'b0, 1'b0, 5'd0, 32'd0);
    rs1_idx = 5'd2;
    rs2_idx = 5'd4;
    #1;
    n_cmp++; if (instret !== 64'd1 || wb_fwd_en !== 1'b1 || rs1_data !== 32'h22) begin
      n_err++; $display("FAIL arst_pre got instret %0d en %b reg2 %h want 1/1/22", instret, wb_fwd_en, rs1_data); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (wb_fwd_en !== 1'b0 || wb_fwd_idx !== 5'd0 || wb_fwd_data !== 32'd0) begin
      n_err++; $display("FAIL arst_fwd got en %b idx %0d data %h want 0/0/0", wb_fwd_en, wb_fwd_idx, wb_fwd_data); end
    n_cmp++; if (instret !== 64'd0 || rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      n_err++; $display("FAIL arst_state got instret %0d reg2 %h reg4 %h want 0/0/0", instret, rs1_data, rs2_data); end
    tick();
    rstn = 1'b1;
    tick();
    n_cmp++; if (rs2_data !== 32'd0 || instret !== 64'd0) begin
      n_err++; $display("FAIL arst_no_write got reg4 %h instret %0d want 0/0", rs2_data, instret); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_x0();
    test_stall();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
